// File: rtl/wb_alu.sv
// wb_alu: Wishbone-mapped WIDTH-bit ALU (ADD/SUB/AND/OR/XOR, shift-add MUL) with status flags.
// Latency: ack one cycle after each accepted request; ALU ops 1 cycle after START, MUL WIDTH+1.
// Backpressure: never stalls (o_wb_stall=0); writes to OPA/OPB/CTRL while BUSY are dropped and flag ERR.
//
// Ports: clk/reset (sync, active-high); Wishbone slave i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr,
//        i_wb_data -> o_wb_ack, o_wb_stall, o_wb_data.
// Registers: +00 OPA, +04 OPB, +08 CTRL{[8] START, [4] SAT, [2:0] OP}, +0C STATUS, +10 RES_LO, +14 RES_HI.
// Optional feature macro: WB_ALU_SAT_EN (CTRL[4] enables unsigned saturating ADD/SUB).
module wb_alu #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int          WIDTH        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic [31:0] o_wb_data
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;
  state_t state, state_nxt;

  logic [WIDTH-1:0] opa, opb, res_lo, res_hi;
  logic [2:0]       op;
`ifdef WB_ALU_SAT_EN
  logic             sat;
`endif
  logic done, carry, ovf, zero, err;
  logic busy;

  logic [2*WIDTH-1:0] mcand, acc, acc_step;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  // ---------------- bus decode ----------------
  logic        req, wr, mapped;
  logic [31:0] off;
  logic [2:0]  idx;
  logic        wr_opa, wr_opb, wr_ctrl, wr_stat, cfg_wr;
  logic        start_req, op_legal, start, illegal, err_set;
  logic        complete, done_clr, err_clr;
  logic [31:0] rdata;
  logic        unused_bits;

  assign req    = i_wb_cyc & i_wb_stb;
  assign off    = i_wb_addr - BASE_ADDRESS;
  // Only word-aligned offsets inside the 6-word window are decoded.
  assign mapped = (off < 32'h18) && (off[1:0] == 2'b00);
  assign idx    = off[4:2];
  assign wr     = req & i_wb_we & mapped;

  assign wr_opa  = wr && (idx == 3'd0);
  assign wr_opb  = wr && (idx == 3'd1);
  assign wr_ctrl = wr && (idx == 3'd2);
  assign wr_stat = wr && (idx == 3'd3);
  assign cfg_wr  = wr_opa | wr_opb | wr_ctrl;

  assign busy      = (state != IDLE);
  assign start_req = wr_ctrl && i_wb_data[8] && !busy;
  assign op_legal  = (i_wb_data[2:0] <= 3'd5);
  assign start     = start_req && op_legal;
  assign illegal   = start_req && !op_legal;
  assign err_set   = (cfg_wr && busy) || illegal;

  assign complete  = ((state == EXEC) && (op != 3'd5)) ||
                     ((state == MUL) && (cnt == CW'(1)));
  assign done_clr  = wr_stat && i_wb_data[1];
  assign err_clr   = wr_stat && i_wb_data[5];

  assign o_wb_stall  = 1'b0;
  // Bits of the write data / address offset that carry no meaning for this map.
  assign unused_bits = ^{i_wb_data, off};

  // ---------------- single-cycle ALU ----------------
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] ex_lo, ex_hi;
  logic             ex_c, ex_v;

  assign sum  = {1'b0, opa} + {1'b0, opb};
  assign diff = {1'b0, opa} - {1'b0, opb};

  always_comb begin
    ex_lo = '0;
    ex_hi = '0;
    ex_c  = 1'b0;
    ex_v  = 1'b0;
    case (op)
      3'd0: begin
        ex_lo = sum[WIDTH-1:0];
        ex_c  = sum[WIDTH];
        ex_hi = WIDTH'(sum[WIDTH]);
        ex_v  = (opa[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
`ifdef WB_ALU_SAT_EN
        if (sat && sum[WIDTH]) ex_lo = '1;
`endif
      end
      3'd1: begin
        ex_lo = diff[WIDTH-1:0];
        ex_c  = diff[WIDTH];  // borrow, i.e. opa < opb unsigned
        ex_v  = (opa[WIDTH-1] != opb[WIDTH-1]) && (diff[WIDTH-1] != opa[WIDTH-1]);
`ifdef WB_ALU_SAT_EN
        if (sat && diff[WIDTH]) ex_lo = '0;
`endif
      end
      3'd2:    ex_lo = opa & opb;
      3'd3:    ex_lo = opa | opb;
      3'd4:    ex_lo = opa ^ opb;
      default: ex_lo = '0;
    endcase
  end

  // One shift-add step: accumulate the shifted multiplicand when the multiplier LSB is set.
  assign acc_step = mplier[0] ? (acc + mcand) : acc;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = EXEC;
      EXEC:    state_nxt = (op == 3'd5) ? MUL : IDLE;
      MUL:     if (cnt == CW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- read mux ----------------
  always_comb begin
    rdata = '0;
    case (idx)
      3'd0: rdata = 32'(opa);
      3'd1: rdata = 32'(opb);
`ifdef WB_ALU_SAT_EN
      3'd2: rdata = {27'd0, sat, 1'b0, op};
`else
      3'd2: rdata = {29'd0, op};
`endif
      3'd3: rdata = {26'd0, err, zero, ovf, carry, done, busy};
      3'd4: rdata = 32'(res_lo);
      3'd5: rdata = 32'(res_hi);
      default: rdata = '0;
    endcase
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
      opa       <= '0;
      opb       <= '0;
      op        <= '0;
`ifdef WB_ALU_SAT_EN
      sat       <= 1'b0;
`endif
      done      <= 1'b0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      err       <= 1'b0;
      res_lo    <= '0;
      res_hi    <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      o_wb_ack  <= req;
      o_wb_data <= (req && !i_wb_we && mapped) ? rdata : 32'd0;

      if (wr_opa && !busy) opa <= i_wb_data[WIDTH-1:0];
      if (wr_opb && !busy) opb <= i_wb_data[WIDTH-1:0];
      if (wr_ctrl && !busy) begin
        op <= i_wb_data[2:0];
`ifdef WB_ALU_SAT_EN
        sat <= i_wb_data[4];
`endif
      end

      // Hardware set wins over a same-edge write-1-to-clear.
      if (start)         done <= 1'b0;
      else if (complete) done <= 1'b1;
      else if (done_clr) done <= 1'b0;

      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;

      if (start) begin
        carry <= 1'b0;
        ovf   <= 1'b0;
        zero  <= 1'b0;
      end

      case (state)
        EXEC: begin
          if (op == 3'd5) begin
            mcand  <= {{WIDTH{1'b0}}, opa};
            mplier <= opb;
            acc    <= '0;
            cnt    <= CW'(WIDTH);
          end else begin
            res_lo <= ex_lo;
            res_hi <= ex_hi;
            carry  <= ex_c;
            ovf    <= ex_v;
            zero   <= (ex_lo == '0) && (ex_hi == '0);
          end
        end
        MUL: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            res_lo <= acc_step[WIDTH-1:0];
            res_hi <= acc_step[2*WIDTH-1:WIDTH];
            carry  <= 1'b0;
            ovf    <= 1'b0;
            zero   <= (acc_step == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_alu.sv
module tb_wb_alu;

  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam logic [31:0] A_OPA = BASE + 32'h00;
  localparam logic [31:0] A_OPB = BASE + 32'h04;
  localparam logic [31:0] A_CTL = BASE + 32'h08;
  localparam logic [31:0] A_ST  = BASE + 32'h0C;
  localparam logic [31:0] A_LO  = BASE + 32'h10;
  localparam logic [31:0] A_HI  = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, wdat = '0;
  logic        ack, stall;
  logic [31:0] rdat;

  int checks = 0;
  int failures = 0;

  // Scoreboard: one entry per issued request; reads carry an expected value.
  bit          rd_q[$];
  logic [31:0] exp_q[$];
  string       name_q[$];

  wb_alu #(.BASE_ADDRESS(BASE), .WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(adr), .i_wb_data(wdat),
    .o_wb_ack(ack), .o_wb_stall(stall), .o_wb_data(rdat)
  );

  always #5 clk = ~clk;

  // Monitor: pops one scoreboard entry per ack, sampled on the falling edge.
  always @(negedge clk) begin
    if (ack) begin
      if (rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack: got ack with empty scoreboard");
      end else begin
        bit          r;
        logic [31:0] e;
        string       n;
        r = rd_q.pop_front();
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (r) begin
          checks++;
          if (rdat !== e) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, rdat, e);
          end
        end
      end
    end
  end

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    rd_q.push_back(1'b0); exp_q.push_back(32'd0); name_q.push_back("wr");
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  // Two writes accepted on consecutive edges.
  task automatic wb_write2(input logic [31:0] a1, input logic [31:0] d1,
                           input logic [31:0] a2, input logic [31:0] d2);
    rd_q.push_back(1'b0); exp_q.push_back(32'd0); name_q.push_back("wr");
    rd_q.push_back(1'b0); exp_q.push_back(32'd0); name_q.push_back("wr");
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a1; wdat = d1;
    @(posedge clk); #1;
    adr = a2; wdat = d2;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] a, input logic [31:0] e, input string n);
    rd_q.push_back(1'b1); exp_q.push_back(e); name_q.push_back(n);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; wdat = 32'd0;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_ack: got %b expected 0", ack);
    end
    reset = 1'b0;
  endtask

  // Single-cycle op vectors: opa, opb, ctrl -> res_lo, res_hi, status.
  localparam int NV = 9;
  logic [7:0]  v_a  [NV] = '{8'hF0, 8'h05, 8'h7F, 8'h80, 8'h03, 8'hF0, 8'hF0, 8'hAA, 8'hFF};
  logic [7:0]  v_b  [NV] = '{8'h20, 8'h05, 8'h01, 8'h01, 8'h05, 8'h3C, 8'h0F, 8'hAA, 8'hFF};
  logic [31:0] v_c  [NV] = '{32'h100, 32'h101, 32'h100, 32'h101, 32'h101, 32'h102, 32'h103, 32'h104, 32'h100};
  logic [7:0]  v_lo [NV] = '{8'h10, 8'h00, 8'h80, 8'h7F, 8'hFE, 8'h30, 8'hFF, 8'h00, 8'hFE};
  logic [7:0]  v_hi [NV] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
  logic [7:0]  v_st [NV] = '{8'h06, 8'h12, 8'h0A, 8'h0A, 8'h06, 8'h02, 8'h02, 8'h12, 8'h06};

  initial begin
    do_reset();
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL stall: got %b expected 0", stall);
    end
    wb_read(A_OPA, 32'h0, "rst_opa");
    wb_read(A_OPB, 32'h0, "rst_opb");
    wb_read(A_CTL, 32'h0, "rst_ctrl");
    wb_read(A_ST,  32'h0, "rst_status");
    wb_read(A_LO,  32'h0, "rst_res_lo");
    wb_read(A_HI,  32'h0, "rst_res_hi");

    // ADD/SUB/logic vectors, back-to-back starts
    for (int i = 0; i < NV; i++) begin
      wb_write(A_OPA, {24'd0, v_a[i]});
      wb_write(A_OPB, {24'd0, v_b[i]});
      wb_write(A_CTL, v_c[i]);
      wb_read(A_LO, {24'd0, v_lo[i]}, $sformatf("vec%0d_res_lo", i));
      wb_read(A_HI, {24'd0, v_hi[i]}, $sformatf("vec%0d_res_hi", i));
      wb_read(A_ST, {24'd0, v_st[i]}, $sformatf("vec%0d_status", i));
    end

    // MUL 0x0D*0x0B: START accepted at edge E0; busy still seen at E9, done at E11
    wb_write(A_OPA, 32'h0D);
    wb_write(A_OPB, 32'h0B);
    wb_write(A_CTL, 32'h105);
    wb_read(A_ST, 32'h01, "mul1_busy_e2");
    @(posedge clk);
    wb_read(A_ST, 32'h01, "mul1_busy_e5");
    wb_read(A_ST, 32'h01, "mul1_busy_e7");
    wb_read(A_ST, 32'h01, "mul1_busy_e9");
    wb_read(A_ST, 32'h02, "mul1_done_e11");
    wb_read(A_LO, 32'h8F, "mul1_res_lo");
    wb_read(A_HI, 32'h00, "mul1_res_hi");

    // MUL 0xFF*0xFF with an OPA write while busy; done visible at E10
    wb_write(A_OPA, 32'hFF);
    wb_write(A_OPB, 32'hFF);
    wb_write(A_CTL, 32'h105);
    wb_read(A_ST, 32'h01, "mul2_busy_e2");
    wb_write(A_OPA, 32'h03);
    wb_read(A_ST, 32'h21, "mul2_busy_err_e6");
    wb_read(A_ST, 32'h21, "mul2_busy_err_e8");
    wb_read(A_ST, 32'h22, "mul2_done_e10");
    wb_read(A_HI, 32'hFE, "mul2_res_hi");
    wb_read(A_LO, 32'h01, "mul2_res_lo");
    wb_read(A_OPA, 32'hFF, "mul2_opa_kept");
    wb_read(A_CTL, 32'h05, "mul2_ctrl_start_rd0");
    wb_write(A_ST, 32'h20);
    wb_read(A_ST, 32'h02, "w1c_err");
    wb_write(A_ST, 32'h02);
    wb_read(A_ST, 32'h00, "w1c_done");

    // Illegal op: no start, ERR set, OP field still updates
    wb_write(A_CTL, 32'h106);
    wb_read(A_ST, 32'h20, "illegal_status");
    wb_read(A_CTL, 32'h06, "illegal_ctrl");

    // START ADD then same-edge W1C of DONE at completion: set wins
    wb_write2(A_CTL, 32'h100, A_ST, 32'h02);
    wb_read(A_ST, 32'h26, "setwins_status");
    wb_read(A_LO, 32'hFE, "setwins_res_lo");
    wb_write(A_ST, 32'h22);
    wb_read(A_ST, 32'h04, "w1c_both");

    // Saturation option
    wb_write(A_OPA, 32'hF0);
    wb_write(A_OPB, 32'h20);
    wb_write(A_CTL, 32'h110);
`ifdef WB_ALU_SAT_EN
    wb_read(A_LO,  32'hFF, "sat_add_res_lo");
    wb_read(A_ST,  32'h06, "sat_add_status");
    wb_read(A_CTL, 32'h10, "sat_ctrl");
`else
    wb_read(A_LO,  32'h10, "nosat_add_res_lo");
    wb_read(A_ST,  32'h06, "nosat_add_status");
    wb_read(A_CTL, 32'h00, "nosat_ctrl");
`endif
    wb_read(A_HI, 32'h01, "sat_add_res_hi");
    wb_write(A_OPA, 32'h03);
    wb_write(A_OPB, 32'h05);
    wb_write(A_CTL, 32'h111);
`ifdef WB_ALU_SAT_EN
    wb_read(A_LO, 32'h00, "sat_sub_res_lo");
    wb_read(A_ST, 32'h16, "sat_sub_status");
`else
    wb_read(A_LO, 32'hFE, "nosat_sub_res_lo");
    wb_read(A_ST, 32'h06, "nosat_sub_status");
`endif

    // Unmapped accesses
    wb_write(BASE + 32'h18, 32'hFFFF_FFFF);
    wb_write(32'h1000_0000, 32'h55);
    wb_read(BASE + 32'h18, 32'h0, "unmapped_18");
    wb_read(BASE + 32'h1C, 32'h0, "unmapped_1c");
    wb_read(32'h2000_0000, 32'h0, "unmapped_other");
    wb_read(A_OPA, 32'h03, "unmapped_wr_ignored");

    // Reset during a multiply discards it
    wb_write(A_CTL, 32'h105);
    @(posedge clk);
    do_reset();
    wb_read(A_ST,  32'h0, "abort_status");
    wb_read(A_LO,  32'h0, "abort_res_lo");
    wb_read(A_HI,  32'h0, "abort_res_hi");
    wb_read(A_OPA, 32'h0, "abort_opa");
    wb_read(A_CTL, 32'h0, "abort_ctrl");

    // Every issued request must have been acknowledged
    repeat (4) @(posedge clk);
    checks++;
    if (rd_q.size() != 0) begin
      failures++;
      $display("FAIL missing_ack: %0d requests pending, expected 0", rd_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
